// File: rtl/pulse_gen.sv
// Edge-triggered pulse generator: a rising edge on en fires one PULSE_WIDTH-cycle
// pulse on out, followed by a HOLDOFF-cycle window in which retriggers are dropped.
module pulse_gen #(
  parameter int PULSE_WIDTH = 4,
  parameter int HOLDOFF     = 16,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out,
  output logic busy
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 65535) begin : g_bad_pulse_width
    $fatal(1, "pulse_gen: PULSE_WIDTH must be in 1..65535");
  end
  if (HOLDOFF < 0 || HOLDOFF > 65535) begin : g_bad_holdoff
    $fatal(1, "pulse_gen: HOLDOFF must be in 0..65535");
  end
  if (CNT_W < 1 || CNT_W > 63 ||
      64'(PULSE_WIDTH) >= (64'd1 << CNT_W) ||
      64'(HOLDOFF) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $fatal(1, "pulse_gen: CNT_W too narrow for PULSE_WIDTH/HOLDOFF");
  end

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_e;

  // Counters load N-1 so that the zero compare lands on the last cycle of each phase.
  localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'(HOLDOFF - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en_prev_q;
  logic             out_q;
  logic             busy_q;
  logic             trig;

  assign trig = en & ~en_prev_q;
  assign out  = out_q;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      en_prev_q <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      en_prev_q <= en;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= PULSE;
            out_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= PW_LOAD;
          end
        end
        PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (HOLDOFF > 0) begin
            state_q <= HOLD;
            out_q   <= 1'b0;
            cnt_q   <= HO_LOAD;
          end else begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: default instance (4/16) plus a 1/0 corner instance.
module tb_pulse_gen;

  logic clk;
  logic rst;
  logic en0, en1;
  logic out0, busy0, out1, busy1;

  int tests_run = 0;
  int tests_failed = 0;

  pulse_gen u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .en   (en0),
    .out  (out0),
    .busy (busy0)
  );

  pulse_gen #(.PULSE_WIDTH(1), .HOLDOFF(0), .CNT_W(16)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en1),
    .out  (out1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pat_en1[11]  = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0};
  int pat_out1[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

  initial begin
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    #2;

    // Reset held for 3 cycles with en toggling; dut1 sees en=1 on the last reset edge.
    for (int i = 0; i < 3; i++) begin
      en0 = (i % 2 == 0);
      en1 = (i != 1);
      step();
      check($sformatf("rst out0 i=%0d", i), 32'(out0), 0);
      check($sformatf("rst busy0 i=%0d", i), 32'(busy0), 0);
      check($sformatf("rst out1 i=%0d", i), 32'(out1), 0);
      check($sformatf("rst busy1 i=%0d", i), 32'(busy1), 0);
    end
    rst = 1'b0;
    en0 = 1'b0;
    en1 = 1'b1;
    step();
    check("post-rst out0", 32'(out0), 0);
    check("post-rst busy0", 32'(busy0), 0);
    check("first-edge out1", 32'(out1), 1);
    check("first-edge busy1", 32'(busy1), 1);
    en1 = 1'b0;
    step();
    check("first-edge end out1", 32'(out1), 0);
    check("first-edge end busy1", 32'(busy1), 0);
    $display("[TB] reset scenario done");

    // Corner instance: every accepted rising edge gives a 1-cycle pulse.
    for (int k = 0; k < 11; k++) begin
      en1 = pat_en1[k][0];
      step();
      check($sformatf("corner out1 k=%0d", k), 32'(out1), 32'(pat_out1[k]));
      check($sformatf("corner busy1 k=%0d", k), 32'(busy1), 32'(pat_out1[k]));
    end
    en1 = 1'b0;
    $display("[TB] corner PW=1 HO=0 scenario done");

    // Single trigger, then an identical one after a 50-cycle idle gap.
    for (int k = 0; k < 96; k++) begin
      en0 = (k == 0 || k == 70);
      step();
      check($sformatf("single out k=%0d", k), 32'(out0),
            32'((k < 4) || (k >= 70 && k < 74)));
      check($sformatf("single busy k=%0d", k), 32'(busy0),
            32'((k < 20) || (k >= 70 && k < 90)));
    end
    $display("[TB] single trigger scenario done");

    // Level held high for 60 cycles, low for one, then high again.
    for (int k = 0; k < 86; k++) begin
      en0 = (k < 60 || k == 61);
      step();
      check($sformatf("level out k=%0d", k), 32'(out0),
            32'((k < 4) || (k >= 61 && k < 65)));
      check($sformatf("level busy k=%0d", k), 32'(busy0),
            32'((k < 20) || (k >= 61 && k < 81)));
    end
    $display("[TB] level hold scenario done");

    // Rising edges at +10 (in holdoff), +20 (HOLD->IDLE edge), +21 (first idle edge).
    for (int k = 0; k < 46; k++) begin
      en0 = (k == 0 || k == 10);
      step();
      check($sformatf("retrig-a out k=%0d", k), 32'(out0), 32'(k < 4));
      check($sformatf("retrig-a busy k=%0d", k), 32'(busy0), 32'(k < 20));
    end
    for (int k = 0; k < 46; k++) begin
      en0 = (k == 0 || k == 20);
      step();
      check($sformatf("retrig-b out k=%0d", k), 32'(out0), 32'(k < 4));
      check($sformatf("retrig-b busy k=%0d", k), 32'(busy0), 32'(k < 20));
    end
    for (int k = 0; k < 46; k++) begin
      en0 = (k == 0 || k == 21);
      step();
      check($sformatf("retrig-c out k=%0d", k), 32'(out0),
            32'((k < 4) || (k >= 21 && k < 25)));
      check($sformatf("retrig-c busy k=%0d", k), 32'(busy0),
            32'((k < 20) || (k >= 21 && k < 41)));
    end
    $display("[TB] retrigger scenario done");

    // Reset two edges into a pulse, then a fresh full pulse.
    for (int k = 0; k < 30; k++) begin
      en0 = (k == 0 || k == 5);
      rst = (k == 2);
      step();
      check($sformatf("midrst out k=%0d", k), 32'(out0),
            32'((k < 2) || (k >= 5 && k < 9)));
      check($sformatf("midrst busy k=%0d", k), 32'(busy0),
            32'((k < 2) || (k >= 5 && k < 25)));
    end
    rst = 1'b0;
    en0 = 1'b0;
    $display("[TB] reset mid-pulse scenario done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Single-clock pulse generator for the delay-line datapath.
- A rising edge on the strobe input `en` launches one output pulse of fixed width on `out`.
- After each pulse, a fixed hold-off window ignores retriggers, so pulses cannot overlap or run back-to-back faster than the line can settle.
- Fully synchronous; registered outputs.

Parameters:
- PULSE_WIDTH, default 4: number of clk cycles `out` stays high per trigger; legal range 1..65535.
- HOLDOFF, default 16: number of clk cycles after the pulse during which triggers are ignored; legal range 0..65535.
- CNT_W, default 16: internal counter width; must satisfy 2^CNT_W > max(PULSE_WIDTH, HOLDOFF).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  trigger strobe; level sampled on clk rising edge, edge-detected internally.
- out  output  1  generated pulse, registered.
- busy  output  1  high while in PULSE or HOLD state, registered.

Behaviour:
- Reset: sampled on a clk rising edge with rst=1. Sets state=IDLE, counter=0, en_d=0, out=0, busy=0. Reset overrides everything, including mid-pulse and mid-holdoff; `out` is low on the edge that samples rst.
- Edge detect: en_d is en registered every cycle (including in PULSE/HOLD). trig = en & ~en_d.
  - en_d resets to 0, so en already high on the first edge after reset counts as a trigger.
- States: IDLE, PULSE, HOLD.
- IDLE:
  - out=0, busy=0.
  - On an edge with trig=1: state<=PULSE, out<=1, busy<=1, counter<=PULSE_WIDTH-1.
  - Latency: out is high immediately after the same clk edge that samples en=1 (0 cycles of extra delay).
- PULSE:
  - out=1, busy=1.
  - While counter!=0: counter decrements each edge.
  - On the edge where counter==0:
    - if HOLDOFF>0: state<=HOLD, out<=0, counter<=HOLDOFF-1;
    - else: state<=IDLE, out<=0, busy<=0.
  - Result: out is high for exactly PULSE_WIDTH consecutive cycles.
- HOLD:
  - out=0, busy=1.
  - Counter decrements each edge. On the edge where counter==0: state<=IDLE, busy<=0.
  - busy is therefore high for exactly PULSE_WIDTH+HOLDOFF cycles.
- Retrigger rules:
  - trig during PULSE or HOLD is ignored and not queued.
  - en held high continuously produces exactly one pulse; a new pulse needs en to return low and rise again while in IDLE.
  - A rising edge on the same edge that HOLD→IDLE occurs is ignored; the earliest accepted trigger is the first edge with state==IDLE.
- Minimum trigger spacing for guaranteed acceptance: PULSE_WIDTH+HOLDOFF+1 cycles.
- Only out and busy are visible outputs; no combinational paths from en to out.
- Illegal parameter values (PULSE_WIDTH=0, counter too narrow) are rejected at elaboration with a fatal error.

Test Plan:
- Reset: hold rst=1 for 3 cycles with en toggling → out=0, busy=0 throughout; deassert rst with en=0 → out stays 0.
- Single trigger (defaults): en=1 for one cycle at edge N, then 0 → out=1 for edges N..N+3 (4 cycles), busy=1 for 20 cycles, then both 0. Repeat after a 50-cycle gap → identical second pulse.
- Level hold: en held high for 60 cycles → exactly one 4-cycle pulse. en low then high again → second pulse.
- Retrigger in holdoff: trigger at N, new rising edge at N+10 → ignored, no second pulse. Rising edge at N+21 → accepted, out high N+21..N+24.
- Reset mid-pulse: trigger at N, rst=1 at N+2 → out=0 and busy=0 after edge N+2; next trigger after reset produces a full 4-cycle pulse.
- Parameter corners: PULSE_WIDTH=1, HOLDOFF=0 → a 1-cycle pulse per rising edge. en toggled 1,0,1,0 each cycle → pulses on every accepted rising edge, back-to-back edges respecting the 2-cycle minimum spacing.
